// File: rtl/sync_pkg.sv
// Shared constants and helpers for the debounce bank.
// Optional long-press detection is enabled by defining SYNC_DEBNC_LONGPRESS_EN.
package sync_pkg;

  // Default configuration and legal limits
  localparam int SYNC_STAGES_DEF     = 2;
  localparam int SYNC_STAGES_MIN     = 2;
  localparam int SYNC_STAGES_MAX     = 4;
  localparam int DEBOUNCE_CYCLES_DEF = 4;
  localparam int DEBOUNCE_CYCLES_MIN = 1;
  localparam int LONG_CYCLES_DEF     = 16;
  localparam int LONG_CYCLES_MIN     = 1;

  // Bits needed to hold values 0..value-1, never less than one bit
  function automatic int clog2(input int value);
    int v;
    int r;
    v = value - 1;
    r = 0;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounce channel: synchroniser chain, debounce counter, edge strobes
// and, when SYNC_DEBNC_LONGPRESS_EN is defined, a long-hold strobe.
module debounce_channel
  import sync_pkg::*;
#(
  parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
`ifdef SYNC_DEBNC_LONGPRESS_EN
  , parameter int LONG_CYCLES   = LONG_CYCLES_DEF
`endif
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic rise,
  output logic fall,
  output logic long_press
);

  localparam int CW = clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   sync_bit;
  logic [CW-1:0]          cnt_reg, cnt_next;
  logic                   level_reg, level_next;
  logic                   rise_reg, rise_next;
  logic                   fall_reg, fall_next;

  assign sync_bit = sync_reg[SYNC_STAGES-1];

  // Plain flop chain: the raw pin enters stage 0, no logic between stages
  always_ff @(posedge clk) begin
    if (rst) sync_reg <= '0;
    else     sync_reg <= {sync_reg[SYNC_STAGES-2:0], raw};
  end

  // Count consecutive disagreements; flip the level only after a full run
  always_comb begin
    cnt_next   = cnt_reg;
    level_next = level_reg;
    rise_next  = 1'b0;
    fall_next  = 1'b0;
    if (sync_bit == level_reg) begin
      cnt_next = '0;
    end else if (cnt_reg == CNT_LAST) begin
      level_next = sync_bit;
      cnt_next   = '0;
      rise_next  = sync_bit;
      fall_next  = ~sync_bit;
    end else begin
      cnt_next = cnt_reg + 1'b1;
    end
  end

  // Debounce state and strobes, strobes land together with the level change
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg   <= '0;
      level_reg <= 1'b0;
      rise_reg  <= 1'b0;
      fall_reg  <= 1'b0;
    end else begin
      cnt_reg   <= cnt_next;
      level_reg <= level_next;
      rise_reg  <= rise_next;
      fall_reg  <= fall_next;
    end
  end

  assign level = level_reg;
  assign rise  = rise_reg;
  assign fall  = fall_reg;

`ifdef SYNC_DEBNC_LONGPRESS_EN
  localparam int HW = clog2(LONG_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_CYCLES);

  logic [HW-1:0] hold_reg, hold_next;
  logic          long_reg, long_next;

  // Hold counter saturates, so the strobe fires once per press
  always_comb begin
    hold_next = hold_reg;
    long_next = 1'b0;
    if (!level_reg) begin
      hold_next = '0;
    end else if (hold_reg != HOLD_MAX) begin
      hold_next = hold_reg + 1'b1;
      long_next = (hold_reg == HOLD_MAX - 1'b1);
    end
  end

  // Hold counter and long-press strobe registers
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_reg <= '0;
      long_reg <= 1'b0;
    end else begin
      hold_reg <= hold_next;
      long_reg <= long_next;
    end
  end

  assign long_press = long_reg;
`else
  assign long_press = 1'b0;
`endif

endmodule

// File: rtl/sync_debounce_bank.sv
// Bank of NCH independent synchronise-and-debounce channels for raw pins.
// Define SYNC_DEBNC_LONGPRESS_EN to build the per-channel long-press strobe;
// otherwise long_press is held at 0.
module sync_debounce_bank
  import sync_pkg::*;
#(
  parameter int NCH             = 5,
  parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int LONG_CYCLES     = LONG_CYCLES_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [NCH-1:0] in,
  output logic [NCH-1:0] out,
  output logic [NCH-1:0] rise,
  output logic [NCH-1:0] fall,
  output logic [NCH-1:0] long_press
);

  // Reject illegal configurations at elaboration
  if (SYNC_STAGES < SYNC_STAGES_MIN || SYNC_STAGES > SYNC_STAGES_MAX) begin : g_bad_sync
    $error("sync_debounce_bank: SYNC_STAGES must be 2..4");
  end
  if (DEBOUNCE_CYCLES < DEBOUNCE_CYCLES_MIN) begin : g_bad_debounce
    $error("sync_debounce_bank: DEBOUNCE_CYCLES must be at least 1");
  end
  if (LONG_CYCLES < LONG_CYCLES_MIN) begin : g_bad_long
    $error("sync_debounce_bank: LONG_CYCLES must be at least 1");
  end

  genvar gi;
  for (gi = 0; gi < NCH; gi++) begin : g_ch
    debounce_channel #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
`ifdef SYNC_DEBNC_LONGPRESS_EN
      , .LONG_CYCLES   (LONG_CYCLES)
`endif
    ) u_ch (
      .clk        (clk),
      .rst        (rst),
      .raw        (in[gi]),
      .level      (out[gi]),
      .rise       (rise[gi]),
      .fall       (fall[gi]),
      .long_press (long_press[gi])
    );
  end

endmodule

// File: tb/tb_sync_debounce_bank.sv
// Directed bench for sync_debounce_bank with default S=2, D=4.
// Long-press expectations follow SYNC_DEBNC_LONGPRESS_EN (LONG_CYCLES=10 when set).
`timescale 1ns/1ps
module tb_sync_debounce_bank;

  localparam int NCH = 5;
`ifdef SYNC_DEBNC_LONGPRESS_EN
  localparam int LONG_CYCLES  = 10;
  localparam int LP_PER_PRESS = 1;
`else
  localparam int LONG_CYCLES  = 16;
  localparam int LP_PER_PRESS = 0;
`endif

  logic           clk = 1'b0;
  logic           rst;
  logic [NCH-1:0] in;
  logic [NCH-1:0] out, rise, fall, long_press;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sync_debounce_bank #(
    .NCH             (NCH),
    .SYNC_STAGES     (2),
    .DEBOUNCE_CYCLES (4),
    .LONG_CYCLES     (LONG_CYCLES)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in         (in),
    .out        (out),
    .rise       (rise),
    .fall       (fall),
    .long_press (long_press)
  );

  // Advance one edge and settle just after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  logic [NCH-1:0] acc;
  int lp_cnt;
  int lp_at;

  initial begin
    rst = 1'b1;
    in  = 5'b11111;

    // Reset held three edges with all inputs high
    ticks(3);
    check("rst_out",  out, 5'b00000);
    check("rst_rise", rise, 5'b00000);
    check("rst_fall", fall, 5'b00000);
    check("rst_lp",   long_press, 5'b00000);

    // Release: first sample at edge r, level flips at r+5
    rst = 1'b0;
    ticks(5);
    check("rel_out_r4", out, 5'b00000);
    tick();
    check("rel_out_r5",  out, 5'b11111);
    check("rel_rise_r5", rise, 5'b11111);
    tick();
    check("rel_rise_r6", rise, 5'b00000);

    // All channels low together: simultaneous falls
    in = 5'b00000;
    ticks(6);
    check("all_fall", fall, 5'b11111);
    check("all_out0", out, 5'b00000);
    ticks(4);

    // Clean step on channel 0
    in = 5'b00001;
    ticks(5);
    check("step_out_k4", out, 5'b00000);
    tick();
    check("step_out_k5",  out, 5'b00001);
    check("step_rise_k5", rise, 5'b00001);
    tick();
    check("step_rise_k6", rise, 5'b00000);
    in = 5'b00000;
    ticks(5);
    check("step_hold_1", out, 5'b00001);
    tick();
    check("step_fall", fall, 5'b00001);
    check("step_out0", out, 5'b00000);
    tick();
    check("step_fall_end", fall, 5'b00000);
    ticks(3);

    // Bounce: three-cycle pulse on channel 2 must be rejected
    acc = '0;
    in  = 5'b00100;
    for (int i = 0; i < 3; i++) begin
      tick();
      acc |= out | rise | fall;
    end
    in = 5'b00000;
    for (int i = 0; i < 10; i++) begin
      tick();
      acc |= out | rise | fall;
    end
    check("bounce_reject", acc, 5'b00000);

    // Four-cycle pulse on channel 2 is just long enough
    in = 5'b00100;
    ticks(4);
    in = 5'b00000;
    ticks(1);
    check("pulse4_k4", out, 5'b00000);
    tick();
    check("pulse4_out",  out, 5'b00100);
    check("pulse4_rise", rise, 5'b00100);
    ticks(8);
    check("pulse4_back", out, 5'b00000);

    // Preset channel 3 high, then swap with channel 1 on one cycle
    in = 5'b01000;
    ticks(8);
    check("preset3", out, 5'b01000);
    in = 5'b00010;
    ticks(5);
    tick();
    check("simul_rise", rise, 5'b00010);
    check("simul_fall", fall, 5'b01000);
    check("simul_out",  out, 5'b00010);
    in = 5'b00000;
    ticks(8);
    check("simul_clear", out, 5'b00000);

    // Reset mid-count on channel 4: count lost, restarted after release
    in = 5'b10000;
    ticks(3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_out", out, 5'b00000);
    acc = '0;
    for (int i = 0; i < 5; i++) begin
      tick();
      acc |= rise | out;
    end
    check("midrst_no_early", acc, 5'b00000);
    tick();
    check("midrst_rise", rise, 5'b10000);
    check("midrst_out1", out, 5'b10000);
    in = 5'b00000;
    ticks(10);
    check("midrst_out0", out, 5'b00000);

    // Long press on channel 0: press, hold, release, press again
    for (int p = 0; p < 2; p++) begin
      in = 5'b00001;
      ticks(6);
      check($sformatf("lp%0d_rise", p), rise, 5'b00001);
      lp_cnt = 0;
      lp_at  = 0;
      acc    = long_press;
      for (int i = 1; i < 40; i++) begin
        tick();
        if (long_press[0]) begin
          lp_cnt++;
          if (lp_at == 0) lp_at = i;
        end
        acc |= long_press & 5'b11110;
      end
      check($sformatf("lp%0d_count", p), lp_cnt, LP_PER_PRESS);
      check($sformatf("lp%0d_delay", p), lp_at, LP_PER_PRESS * 10);
      check($sformatf("lp%0d_others", p), acc, 5'b00000);
      in = 5'b00000;
      ticks(12);
      check($sformatf("lp%0d_release", p), out, 5'b00000);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
